// File: rtl/spram_arbiter_if.sv
// Bus bundle between the CPU's instruction/data ports, the SPRAM arbiter
// and the SPRAM wrapper. The arbiter takes the slave view; the core and
// memory side (or a testbench standing in for them) take the master view.
interface spram_arbiter_if #(
  parameter int ADDR_WIDTH = 14
);
  // Instruction-fetch port: read-only requests
  logic                  i_valid;
  logic                  i_ready;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic                  i_rvalid;
  logic [31:0]           i_rdata;

  // Data port: reads and byte-masked writes
  logic                  d_valid;
  logic                  d_ready;
  logic                  d_wen;
  logic [3:0]            d_wmask;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [31:0]           d_wdata;
  logic                  d_rvalid;
  logic [31:0]           d_rdata;

  // SPRAM wrapper side
  logic                  mem_wen;
  logic [3:0]            mem_wmask;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic [31:0]           mem_rdata;

  modport slave (
    input  i_valid, i_addr,
    output i_ready, i_rvalid, i_rdata,
    input  d_valid, d_wen, d_wmask, d_addr, d_wdata,
    output d_ready, d_rvalid, d_rdata,
    output mem_wen, mem_wmask, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output i_valid, i_addr,
    input  i_ready, i_rvalid, i_rdata,
    output d_valid, d_wen, d_wmask, d_addr, d_wdata,
    input  d_ready, d_rvalid, d_rdata,
    input  mem_wen, mem_wmask, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/spram_arbiter.sv
// Two-port arbiter in front of the single-port 32-bit SPRAM. One request
// (I fetch or D load/store) is granted per cycle; the SPRAM answers one
// cycle later and the answer is routed back to whichever port issued it.
module spram_arbiter #(
  parameter int ADDR_WIDTH  = 14,
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  spram_arbiter_if.slave   bus
);

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_e;

  // Describes the access currently inside the SPRAM pipeline stage.
  typedef struct packed {
    logic  valid;
    port_e owner;
    logic  is_read;
  } tag_t;

  port_e                 last_grant;
  tag_t                  inflight;
  logic                  grant_i;
  logic                  grant_d;
  logic                  resp_i;
  logic                  resp_d;
  logic [31:0]           i_rdata_q;
  logic [31:0]           d_rdata_q;
  logic                  sel_wen;
  logic [3:0]            sel_wmask;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [31:0]           sel_wdata;

  // Pick this cycle's winner; nothing is granted while reset is held.
  always_comb begin
    // NOTE: defaults first, so every path assigns both grants and no latch is inferred.
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (!reset) begin
      if (bus.i_valid && bus.d_valid) begin
        if (ROUND_ROBIN) begin
          grant_d = (last_grant == PORT_I);
        end else begin
          grant_d = 1'b1;
        end
        grant_i = !grant_d;
      end else begin
        grant_i = bus.i_valid;
        grant_d = bus.d_valid;
      end
    end
  end

  assign bus.i_ready = grant_i;
  assign bus.d_ready = grant_d;

  // Steer the granted port onto the SPRAM; idle cycles become a harmless I-address read.
  always_comb begin
    sel_wen   = 1'b0;
    sel_wmask = 4'b0000;
    sel_addr  = bus.i_addr;
    sel_wdata = '0;
    if (grant_d) begin
      sel_wen   = bus.d_wen;
      sel_wmask = bus.d_wmask;
      sel_addr  = bus.d_addr;
      sel_wdata = bus.d_wdata;
    end
  end

  assign bus.mem_wen   = sel_wen;
  assign bus.mem_wmask = sel_wmask;
  assign bus.mem_addr  = sel_addr;
  assign bus.mem_wdata = sel_wdata;

  // Tag the access issued at this edge and remember who won, for alternation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight   <= '0;
      last_grant <= PORT_I;
    end else begin
      // NOTE: non-blocking updates, so every flop sees pre-edge values regardless of statement order.
      inflight.valid   <= grant_i | grant_d;
      inflight.owner   <= grant_d ? PORT_D : PORT_I;
      inflight.is_read <= grant_i | ~bus.d_wen;
      if (grant_i || grant_d) begin
        last_grant <= grant_d ? PORT_D : PORT_I;
      end
    end
  end

  assign resp_i = inflight.valid && (inflight.owner == PORT_I);
  assign resp_d = inflight.valid && (inflight.owner == PORT_D);

  // Keep the last read word per port so rdata stays stable between responses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      if (resp_i) begin
        i_rdata_q <= bus.mem_rdata;
      end
      if (resp_d && inflight.is_read) begin
        d_rdata_q <= bus.mem_rdata;
      end
    end
  end

  // During the response cycle the SPRAM output is forwarded directly, so the
  // data arrives together with rvalid; afterwards the held copy is shown.
  assign bus.i_rvalid = resp_i;
  assign bus.d_rvalid = resp_d;
  assign bus.i_rdata  = resp_i ? bus.mem_rdata : i_rdata_q;
  assign bus.d_rdata  = (resp_d && inflight.is_read) ? bus.mem_rdata : d_rdata_q;

endmodule

// File: tb/tb_spram_arbiter.sv
// Bench for spram_arbiter. Two instances (round-robin and fixed-priority)
// see identical request streams; each has its own SPRAM model and its own
// reference model that derives grants and responses from the arbitration
// rules and a shadow memory updated on every accepted write.
module tb_spram_arbiter;

  localparam int AW        = 14;
  localparam int MEM_WORDS = 1 << AW;

  logic          clk     = 1'b0;
  logic          reset   = 1'b1;
  logic          i_valid = 1'b0;
  logic [AW-1:0] i_addr  = '0;
  logic          d_valid = 1'b0;
  logic          d_wen   = 1'b0;
  logic [3:0]    d_wmask = 4'b0000;
  logic [AW-1:0] d_addr  = '0;
  logic [31:0]   d_wdata = '0;

  int checks = 0;
  int errors = 0;

  // Index 0: ROUND_ROBIN=1, index 1: ROUND_ROBIN=0
  logic        obs_i_ready  [2];
  logic        obs_d_ready  [2];
  logic        obs_i_rvalid [2];
  logic        obs_d_rvalid [2];
  logic [31:0] obs_i_rdata  [2];
  logic [31:0] obs_d_rdata  [2];

  always #5 clk = ~clk;

  task automatic check(input int inst, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL inst%0d %s actual=%h expected=%h at %0t", inst, name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input int a);
    if (a == 'h10) return 32'hDEADBEEF;
    if (a == 'h20) return 32'hAAAAAAAA;
    return (32'(a) * 32'h0001_0003) ^ 32'h5A5A_5A5A;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (m[b]) r[8*b +: 8] = wd[8*b +: 8];
    end
    return r;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam bit RR = (g == 0);

    spram_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

    spram_arbiter #(.ADDR_WIDTH(AW), .ROUND_ROBIN(RR)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
    );

    assign bus.i_valid = i_valid;
    assign bus.i_addr  = i_addr;
    assign bus.d_valid = d_valid;
    assign bus.d_wen   = d_wen;
    assign bus.d_wmask = d_wmask;
    assign bus.d_addr  = d_addr;
    assign bus.d_wdata = d_wdata;

    assign obs_i_ready[g]  = bus.i_ready;
    assign obs_d_ready[g]  = bus.d_ready;
    assign obs_i_rvalid[g] = bus.i_rvalid;
    assign obs_d_rvalid[g] = bus.d_rvalid;
    assign obs_i_rdata[g]  = bus.i_rdata;
    assign obs_d_rdata[g]  = bus.d_rdata;

    // SPRAM: one access per edge, read data registered
    logic [31:0] spram [MEM_WORDS];
    initial for (int a = 0; a < MEM_WORDS; a++) spram[a] <= init_word(a);
    always @(posedge clk) begin
      if (bus.mem_wen) spram[bus.mem_addr] <= merge(spram[bus.mem_addr], bus.mem_wdata, bus.mem_wmask);
      bus.mem_rdata <= spram[bus.mem_addr];
    end

    // Reference model state
    logic [31:0] ref_mem [MEM_WORDS];
    initial for (int a = 0; a < MEM_WORDS; a++) ref_mem[a] <= init_word(a);
    logic        m_last_d   = 1'b0;
    logic        m_due      = 1'b0;
    logic        m_due_d    = 1'b0;
    logic        m_due_read = 1'b0;
    logic [31:0] m_due_data = '0;
    logic [31:0] m_held_i   = '0;
    logic [31:0] m_held_d   = '0;

    always @(negedge clk) begin : model
      logic        exp_i_rdy, exp_d_rdy;
      logic [31:0] nxt_i, nxt_d;
      if (reset) begin
        check(g, "i_ready in reset", bus.i_ready, 0);
        check(g, "d_ready in reset", bus.d_ready, 0);
        check(g, "i_rvalid in reset", bus.i_rvalid, 0);
        check(g, "d_rvalid in reset", bus.d_rvalid, 0);
        check(g, "i_rdata in reset", bus.i_rdata, 0);
        check(g, "d_rdata in reset", bus.d_rdata, 0);
        m_last_d <= 1'b0;
        m_due    <= 1'b0;
        m_held_i <= '0;
        m_held_d <= '0;
      end else begin
        nxt_i = m_held_i;
        nxt_d = m_held_d;
        if (m_due && m_due_read) begin
          if (m_due_d) nxt_d = m_due_data;
          else         nxt_i = m_due_data;
        end
        check(g, "i_rvalid", bus.i_rvalid, m_due && !m_due_d);
        check(g, "d_rvalid", bus.d_rvalid, m_due && m_due_d);
        check(g, "i_rdata", bus.i_rdata, nxt_i);
        check(g, "d_rdata", bus.d_rdata, nxt_d);

        if (i_valid && d_valid) exp_d_rdy = RR ? !m_last_d : 1'b1;
        else                    exp_d_rdy = d_valid;
        exp_i_rdy = i_valid && !exp_d_rdy;
        check(g, "i_ready", bus.i_ready, exp_i_rdy);
        check(g, "d_ready", bus.d_ready, exp_d_rdy);

        m_held_i   <= nxt_i;
        m_held_d   <= nxt_d;
        m_due      <= exp_i_rdy || exp_d_rdy;
        m_due_d    <= exp_d_rdy;
        m_due_read <= exp_i_rdy || !d_wen;
        m_due_data <= exp_d_rdy ? ref_mem[d_addr] : ref_mem[i_addr];
        if (exp_d_rdy && d_wen) ref_mem[d_addr] <= merge(ref_mem[d_addr], d_wdata, d_wmask);
        if (exp_i_rdy || exp_d_rdy) m_last_d <= exp_d_rdy;
      end
    end
  end

  initial begin
    int   n_i, n_d;
    logic hold_i, hold_d;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Lone I read of a preloaded word
    i_valid = 1'b1;
    i_addr  = AW'('h10);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check(k, "t1 i_ready", obs_i_ready[k], 1);
      check(k, "t1 d_ready", obs_d_ready[k], 0);
    end
    @(posedge clk); #1 i_valid = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check(k, "t1 i_rvalid", obs_i_rvalid[k], 1);
      check(k, "t1 i_rdata", obs_i_rdata[k], 32'hDEADBEEF);
      check(k, "t1 d_rvalid", obs_d_rvalid[k], 0);
    end

    // Masked D write then read-back
    @(posedge clk); #1;
    d_valid = 1'b1;
    d_wen   = 1'b1;
    d_wmask = 4'b0101;
    d_addr  = AW'('h20);
    d_wdata = 32'h11223344;
    @(negedge clk);
    for (int k = 0; k < 2; k++) check(k, "t2 write d_ready", obs_d_ready[k], 1);
    @(posedge clk); #1 d_wen = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check(k, "t2 write d_rvalid", obs_d_rvalid[k], 1);
      check(k, "t2 d_rdata kept", obs_d_rdata[k], 32'h0);
    end
    @(posedge clk); #1 d_valid = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check(k, "t2 read d_rvalid", obs_d_rvalid[k], 1);
      check(k, "t2 read d_rdata", obs_d_rdata[k], 32'hAA22AA44);
    end

    // Continuous contention from reset
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    reset   = 1'b0;
    i_valid = 1'b1;
    i_addr  = AW'('h11);
    d_valid = 1'b1;
    d_wen   = 1'b0;
    d_addr  = AW'('h21);
    n_i = 0;
    n_d = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check(0, "t3 d_ready", obs_d_ready[0], (c % 2 == 0) ? 1 : 0);
      check(0, "t3 i_ready", obs_i_ready[0], (c % 2 == 1) ? 1 : 0);
      check(1, "t4 d_ready", obs_d_ready[1], 1);
      check(1, "t4 i_ready", obs_i_ready[1], 0);
      n_i += int'(obs_i_rvalid[0]);
      n_d += int'(obs_d_rvalid[0]);
      @(posedge clk); #1;
    end
    d_valid = 1'b0;
    @(negedge clk);
    check(1, "t4 i_ready after d drops", obs_i_ready[1], 1);
    n_i += int'(obs_i_rvalid[0]);
    n_d += int'(obs_d_rvalid[0]);
    check(0, "t3 i responses", n_i, 4);
    check(0, "t3 d responses", n_d, 4);
    @(posedge clk); #1 i_valid = 1'b0;

    // Reset lands while an I read is in flight
    @(posedge clk); #1;
    i_valid = 1'b1;
    i_addr  = AW'('h10);
    @(negedge clk);
    check(0, "t5 i_ready", obs_i_ready[0], 1);
    @(posedge clk); #1;
    reset   = 1'b1;
    d_valid = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check(k, "t5 i_rvalid", obs_i_rvalid[k], 0);
      check(k, "t5 i_rdata", obs_i_rdata[k], 0);
      check(k, "t5 i_ready", obs_i_ready[k], 0);
      check(k, "t5 d_ready", obs_d_ready[k], 0);
    end
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check(0, "t5 d wins after reset", obs_d_ready[0], 1);
    check(0, "t5 i loses after reset", obs_i_ready[0], 0);
    @(posedge clk); #1;
    i_valid = 1'b0;
    d_valid = 1'b0;

    // Random traffic; a request is held until both instances have taken it
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      hold_i = i_valid && !(obs_i_ready[0] && obs_i_ready[1]);
      hold_d = d_valid && !(obs_d_ready[0] && obs_d_ready[1]);
      @(posedge clk); #1;
      reset = (c % 2000 == 999);
      if (!hold_i) begin
        i_valid = ($urandom_range(0, 99) < 60);
        i_addr  = AW'($urandom_range(0, 63));
      end
      if (!hold_d) begin
        d_valid = ($urandom_range(0, 99) < 50);
        d_wen   = 1'($urandom_range(0, 1));
        d_wmask = 4'($urandom_range(0, 15));
        d_addr  = AW'($urandom_range(0, 63));
        d_wdata = $urandom;
      end
    end

    @(posedge clk); #1;
    i_valid = 1'b0;
    d_valid = 1'b0;
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
